// File: rtl/uart_rx_pkg.sv
// Shared defaults and helpers for the UART receive sampler slice.
package uart_rx_pkg;

    localparam int PRESCALE_W_DEFAULT = 6;
    localparam int BIT_CNT_W_DEFAULT  = 4;
    localparam logic IDLE_LEVEL       = 1'b1;
    localparam int MIN_PRESCALE       = 4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Bundles the serial input, counter controls and sampler outputs of uart_rx_sampler.
interface uart_rx_sampler_if
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEFAULT
);

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  cnt_en;
    logic                  smp_en;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  bit_done;
    logic                  sampled_bit;
    logic                  smp_valid;

    modport master (
        output RX_IN, prescale, cnt_en, smp_en,
        input  edge_cnt, bit_cnt, bit_done, sampled_bit, smp_valid
    );

    modport slave (
        input  RX_IN, prescale, cnt_en, smp_en,
        output edge_cnt, bit_cnt, bit_done, sampled_bit, smp_valid
    );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Tracks the cycle position inside a bit and the number of bits completed in the frame.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cnt_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] p_eff,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] MIN_P   = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [PRESCALE_W-1:0] LSB_CLR = {{(PRESCALE_W-1){1'b1}}, 1'b0};

    logic [PRESCALE_W-1:0] p_even;

    // Odd ratios round down, tiny ratios clamp so three sample points always fit.
    assign p_even = prescale & LSB_CLR;
    assign p_eff  = (p_even < MIN_P) ? MIN_P : p_even;

    // Using >= lets a mid-bit prescale reduction wrap on the very next cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
        end else if (edge_cnt >= p_eff - PRESCALE_W'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            bit_done <= 1'b1;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
            bit_done <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive synchronizer, bit timing and mid-bit sampler.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote instead of the centre sample.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_sampler_if.slave bus
);

    logic                  rx_meta;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] p_eff;
    logic [PRESCALE_W-1:0] half_p;
    logic                  at_s2;
    logic                  decided;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= IDLE_LEVEL;
            rx_s    <= IDLE_LEVEL;
        end else begin
            rx_meta <= bus.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .cnt_en   (bus.cnt_en),
        .prescale (bus.prescale),
        .p_eff    (p_eff),
        .edge_cnt (bus.edge_cnt),
        .bit_cnt  (bus.bit_cnt),
        .bit_done (bus.bit_done)
    );

    assign half_p = p_eff >> 1;
    assign at_s2  = bus.cnt_en && (bus.edge_cnt == half_p);

`ifdef UART_RX_MAJORITY_EN
    logic s0;
    logic s1;

    // Early samples are taken even with smp_en low so the vote is ready whenever it is enabled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (bus.cnt_en) begin
            if (bus.edge_cnt == half_p - PRESCALE_W'(2)) begin
                s0 <= rx_s;
            end
            if (bus.edge_cnt == half_p - PRESCALE_W'(1)) begin
                s1 <= rx_s;
            end
        end
    end

    assign decided = majority3(s0, s1, rx_s);
`else
    assign decided = rx_s;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.sampled_bit <= IDLE_LEVEL;
            bus.smp_valid   <= 1'b0;
        end else begin
            bus.smp_valid <= at_s2 && bus.smp_en;
            if (at_s2 && bus.smp_en) begin
                bus.sampled_bit <= decided;
            end
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of prescale and edge_cnt.
REQ-002 SHALL have parameter BIT_CNT_W, default 4, width of bit_cnt.
REQ-003 SHALL have port CLK  input  1  clock; all flops on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port prescale  input  PRESCALE_W  oversampling ratio, CLK cycles per bit.
REQ-007 SHALL have port cnt_en  input  1  enables edge/bit counting.
REQ-008 SHALL have port smp_en  input  1  enables bit sampling.
REQ-009 SHALL have port edge_cnt  output  PRESCALE_W  cycle position within the current bit.
REQ-010 SHALL have port bit_cnt  output  BIT_CNT_W  bits completed in the current frame.
REQ-011 SHALL have port bit_done  output  1  one-cycle pulse at each bit boundary.
REQ-012 SHALL have port sampled_bit  output  1  latest decided bit value; feeds start/parity/stop checkers.
REQ-013 SHALL have port smp_valid  output  1  one-cycle pulse when sampled_bit is updated.

Function
REQ-014 SHALL pass RX_IN through a 2-flop synchronizer (rx_s) before any use; 2 CLK latency.
REQ-015 SHALL use effective prescale P = max(prescale & ~1, 4), i.e. LSB ignored and values below 4 forced to 4.
REQ-016 With cnt_en=1, edge_cnt SHALL increment by 1 each CLK and wrap to 0 on the cycle after edge_cnt==P-1.
REQ-017 On that wrap, bit_cnt SHALL increment by 1, modulo 2^BIT_CNT_W, and bit_done SHALL be 1 for exactly that cycle (edge_cnt==0).
REQ-018 With cnt_en=0, edge_cnt, bit_cnt and bit_done SHALL be driven to 0 at the next CLK edge; cnt_en low for one cycle mid-bit restarts counting from 0.
REQ-019 Sample points SHALL be edge_cnt==P/2-2 (s0), P/2-1 (s1) and P/2 (s2).
REQ-020 With smp_en=1, the edge at which edge_cnt==P/2 SHALL load sampled_bit with the decided value and set smp_valid=1 for one cycle (visible at edge_cnt==P/2+1).
REQ-021 With smp_en=0, sampled_bit SHALL hold, smp_valid SHALL be 0, and the s0/s1 captures SHALL still occur.
REQ-022 A prescale change mid-bit SHALL take effect immediately, and any edge_cnt>=new P-1 SHALL wrap on the next CLK.
REQ-023 Sampling SHALL only occur while cnt_en=1.

Reset
REQ-024 RST low SHALL asynchronously force synchronizer flops and sampled_bit to 1, and edge_cnt, bit_cnt, bit_done, smp_valid, s0 and s1 to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no smp_valid or bit_done pulse, and counting SHALL resume only after release with cnt_en=1.

Configuration
REQ-026 With macro UART_RX_MAJORITY_EN defined, the decided value SHALL be the majority of s0, s1 and s2.
REQ-027 Without UART_RX_MAJORITY_EN, the decided value SHALL be s2 alone, and the s0/s1 flops SHALL be absent; timing of sampled_bit and smp_valid SHALL be identical.

Structure
REQ-028 Package uart_rx_pkg SHALL hold PRESCALE_W and BIT_CNT_W defaults, IDLE_LEVEL=1 and MIN_PRESCALE=4.
REQ-029 Edge/bit counting SHALL be a sub-module uart_rx_edge_bit_counter; synchronizer and voter SHALL be in the top.

Verification
REQ-030 SHALL cover: P=8, cnt_en=1 held 16 cycles -> edge_cnt 0..7,0..7; bit_done high at cycles 8 and 16; bit_cnt 2.
REQ-031 SHALL cover: P=8, RX_IN=0 for a full bit (after 2-cycle sync) -> sampled_bit=0 with smp_valid pulse at edge_cnt==5.
REQ-032 SHALL cover: P=16, rx_s=1 only at edge_cnt==6 within a 0 bit -> with macro sampled_bit=0; without macro sampled_bit=0.
REQ-033 SHALL cover: P=16, rx_s=1 only at edge_cnt==8 -> with macro sampled_bit=0; without macro sampled_bit=1.
REQ-034 SHALL cover: prescale=5 and prescale=2 -> behave as P=4 and P=4, bit_done every 4 cycles.
REQ-035 SHALL cover: RST low at edge_cnt==3 of bit 2 -> all counters 0 and sampled_bit=1 immediately; no pulses until cnt_en reasserted.
